// File: rtl/line_tap_gen_pkg.sv
// Shared defaults and helpers for the median/edge pipeline stages
// (line tap generator, sorter, median).
package line_tap_gen_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Single-clock line memory: one write port and one registered read port,
// read-before-write when both ports hit the same address.
module line_buffer_ram
    import line_tap_gen_pkg::*;
#(
    parameter int DEPTH  = DEF_IMG_WIDTH,
    parameter int WIDTH  = DEF_DATA_W,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    // Storage is intentionally not reset; downstream valid gating covers it.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/line_tap_gen.sv
// Turns a 1-pixel-per-cycle raster stream into vertically aligned column
// triples (rows n-2, n-1, n) with one cycle of latency.
module line_tap_gen
    import line_tap_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int DATA_W     = DEF_DATA_W,
    localparam int COL_W     = clog2(IMG_WIDTH),
    localparam int ROW_W     = clog2(IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] tap_top,
    output logic [DATA_W-1:0] tap_mid,
    output logic [DATA_W-1:0] tap_bot,
    output logic              tap_valid,
    output logic [COL_W-1:0]  tap_col,
    output logic [ROW_W-1:0]  tap_row,
    output logic              frame_done
);

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] FIRST_OUT = ROW_W'(2);

    logic              accept;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;

    logic [COL_W-1:0]  col_d, col_q;
    logic [ROW_W-1:0]  row_d, row_q;
    logic [DATA_W-1:0] tap_bot_d, tap_bot_q;
    logic [COL_W-1:0]  tap_col_d, tap_col_q;
    logic [ROW_W-1:0]  tap_row_d, tap_row_q;
    logic              tap_valid_d, tap_valid_q;
    logic              frame_done_d, frame_done_q;
    logic              lb_b_wr_d, lb_b_wr_q;
    logic [COL_W-1:0]  lb_b_col_d, lb_b_col_q;

    logic [DATA_W-1:0] lb_a_rd_data;
    logic [DATA_W-1:0] lb_b_rd_data;

    assign accept = pix_valid;

    // sof relocates the accepted pixel to (0,0); on a natural wrap the
    // counters already sit at (0,0), so sof there is a no-op.
    always_comb begin
        cur_col = col_q;
        cur_row = row_q;
        if (sof) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        tap_bot_d    = tap_bot_q;
        tap_col_d    = tap_col_q;
        tap_row_d    = tap_row_q;
        tap_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_b_wr_d    = accept;
        lb_b_col_d   = lb_b_col_q;
        if (accept) begin
            if (cur_col == LAST_COL) begin
                col_d = '0;
                row_d = (cur_row == LAST_ROW) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
            tap_bot_d    = pix_in;
            tap_col_d    = cur_col;
            tap_row_d    = cur_row;
            tap_valid_d  = (cur_row >= FIRST_OUT);
            frame_done_d = (cur_col == LAST_COL) && (cur_row == LAST_ROW);
            lb_b_col_d   = cur_col;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            tap_bot_q    <= '0;
            tap_col_q    <= '0;
            tap_row_q    <= '0;
            tap_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            lb_b_wr_q    <= 1'b0;
            lb_b_col_q   <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            tap_bot_q    <= tap_bot_d;
            tap_col_q    <= tap_col_d;
            tap_row_q    <= tap_row_d;
            tap_valid_q  <= tap_valid_d;
            frame_done_q <= frame_done_d;
            lb_b_wr_q    <= lb_b_wr_d;
            lb_b_col_q   <= lb_b_col_d;
        end
    end

    // lb_a holds row n-1; its read data migrates into lb_b (row n-2) one
    // cycle later at the column it was read from.
    line_buffer_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_W)
    ) lb_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (cur_col),
        .wr_data (pix_in),
        .rd_en   (accept),
        .rd_addr (cur_col),
        .rd_data (lb_a_rd_data)
    );

    line_buffer_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_W)
    ) lb_b (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (lb_b_wr_q),
        .wr_addr (lb_b_col_q),
        .wr_data (lb_a_rd_data),
        .rd_en   (accept),
        .rd_addr (cur_col),
        .rd_data (lb_b_rd_data)
    );

    assign tap_top    = lb_b_rd_data;
    assign tap_mid    = lb_a_rd_data;
    assign tap_bot    = tap_bot_q;
    assign tap_valid  = tap_valid_q;
    assign tap_col    = tap_col_q;
    assign tap_row    = tap_row_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_tap_gen.sv
// Directed, table-driven bench for line_tap_gen on a 4x4 image with
// pixel value = row*16 + col.
module tb_line_tap_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk;
    logic       rst;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       sof;
    logic [7:0] tap_top;
    logic [7:0] tap_mid;
    logic [7:0] tap_bot;
    logic       tap_valid;
    logic [1:0] tap_col;
    logic [1:0] tap_row;
    logic       frame_done;

    line_tap_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .tap_top    (tap_top),
        .tap_mid    (tap_mid),
        .tap_bot    (tap_bot),
        .tap_valid  (tap_valid),
        .tap_col    (tap_col),
        .tap_row    (tap_row),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic       sof;
        logic [7:0] pix;
        logic       exp_valid;
        logic       exp_fd;
        logic [7:0] exp_top;
        logic [7:0] exp_mid;
        logic [7:0] exp_bot;
        logic [1:0] exp_col;
        logic [1:0] exp_row;
        logic       chk_taps;
    } vec_t;

    vec_t vecs[$];
    vec_t last_vec;
    int   checks;
    int   errors;
    int   vec_num;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (vec %0d)", name, act, exp, vec_num);
        end
    endtask

    // Accepted pixel at logical position (c,r); expected taps follow directly
    // from the pixel numbering.
    task automatic add_pixel(input int c, input int r, input logic s);
        vec_t v;
        v.valid     = 1'b1;
        v.sof       = s;
        v.pix       = 8'(r * 16 + c);
        v.exp_valid = (r >= 2);
        v.exp_fd    = (c == W - 1) && (r == H - 1);
        v.exp_top   = (r >= 2) ? 8'((r - 2) * 16 + c) : 8'h00;
        v.exp_mid   = (r >= 2) ? 8'((r - 1) * 16 + c) : 8'h00;
        v.exp_bot   = 8'(r * 16 + c);
        v.exp_col   = 2'(c);
        v.exp_row   = 2'(r);
        v.chk_taps  = (r >= 2);
        vecs.push_back(v);
        last_vec = v;
    endtask

    // Idle cycle: taps hold, valid and frame_done drop.
    task automatic add_idle(input logic s);
        vec_t v;
        v           = last_vec;
        v.valid     = 1'b0;
        v.sof       = s;
        v.pix       = 8'hEE;
        v.exp_valid = 1'b0;
        v.exp_fd    = 1'b0;
        vecs.push_back(v);
        last_vec = v;
    endtask

    task automatic add_frame(input logic with_idle);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                add_pixel(c, r, (c == 0) && (r == 0));
                if (with_idle) add_idle(1'b0);
            end
        end
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(negedge clk);
            pix_valid = vecs[i].valid;
            sof       = vecs[i].sof;
            pix_in    = vecs[i].pix;
            @(posedge clk);
            #1;
            vec_num++;
            $display("vec %0d: v=%b sof=%b pix=%h -> tv=%b col=%0d row=%0d top=%h mid=%h bot=%h fd=%b",
                     vec_num, vecs[i].valid, vecs[i].sof, vecs[i].pix, tap_valid, tap_col,
                     tap_row, tap_top, tap_mid, tap_bot, frame_done);
            check("tap_valid", 32'(tap_valid), 32'(vecs[i].exp_valid));
            check("frame_done", 32'(frame_done), 32'(vecs[i].exp_fd));
            check("tap_col", 32'(tap_col), 32'(vecs[i].exp_col));
            check("tap_row", 32'(tap_row), 32'(vecs[i].exp_row));
            check("tap_bot", 32'(tap_bot), 32'(vecs[i].exp_bot));
            if (vecs[i].chk_taps) begin
                check("tap_top", 32'(tap_top), 32'(vecs[i].exp_top));
                check("tap_mid", 32'(tap_mid), 32'(vecs[i].exp_mid));
            end
        end
        vecs.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_top"}, 32'(tap_top), 32'h0);
        check({tag, "_mid"}, 32'(tap_mid), 32'h0);
        check({tag, "_bot"}, 32'(tap_bot), 32'h0);
        check({tag, "_valid"}, 32'(tap_valid), 32'h0);
        check({tag, "_col"}, 32'(tap_col), 32'h0);
        check({tag, "_row"}, 32'(tap_row), 32'h0);
        check({tag, "_fd"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        vec_num   = 0;
        rst       = 1'b1;
        pix_in    = 8'h00;
        pix_valid = 1'b0;
        sof       = 1'b0;

        @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Continuous frame, then a second frame with sof directly after 0x33.
        add_frame(1'b0);
        add_frame(1'b0);
        run_vecs();

        // pix_valid toggling every cycle.
        add_frame(1'b1);
        run_vecs();

        // sof at (2,2) abandons the frame; a fresh frame follows.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++)
                add_pixel(c, r, (c == 0) && (r == 0));
        add_pixel(0, 2, 1'b0);
        add_pixel(1, 2, 1'b0);
        add_frame(1'b0);
        run_vecs();

        // sof without pix_valid mid-frame is ignored.
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                add_pixel(c, r, (c == 0) && (r == 0));
                if ((r == 2) && (c == 1)) begin
                    add_idle(1'b1);
                    add_idle(1'b1);
                    add_idle(1'b1);
                end
            end
        end
        run_vecs();

        // Reset pulsed while (1,3) is being presented.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if ((r < 3) || (c == 0)) add_pixel(c, r, (c == 0) && (r == 0));
        run_vecs();
        @(negedge clk);
        pix_in    = 8'h31;
        pix_valid = 1'b1;
        sof       = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        @(negedge clk);
        rst       = 1'b0;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(tap_valid), 32'h0);
        check("post_rst_fd", 32'(frame_done), 32'h0);

        add_frame(1'b0);
        run_vecs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_tap_gen.md
Name: line_tap_gen

Overview:
- Produces three vertically aligned pixels per column from a raster pixel stream: rows n-2, n-1 and n.
- Sits directly upstream of the 3-input sorting stage of the median/edge pipeline.
- Turns a 1-pixel-per-cycle camera/frame stream into the column triples that the sorter consumes.
- Holds two line delays internally and tracks column, row and frame position.

Parameters:
- IMG_WIDTH, 640, pixels per line (≥4)
- IMG_HEIGHT, 480, lines per frame (≥3)
- DATA_W, 8, pixel width in bits

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous active-high reset
- pix_in  in  DATA_W  input pixel, raster order
- pix_valid  in  1  pix_in valid this cycle; no backpressure
- sof  in  1  start of frame; qualified by pix_valid, marks first pixel of a frame
- tap_top  out  DATA_W  pixel from row n-2, same column
- tap_mid  out  DATA_W  pixel from row n-1, same column
- tap_bot  out  DATA_W  pixel from row n (current)
- tap_valid  out  1  taps valid (row ≥2)
- tap_col  out  clog2(IMG_WIDTH)  column of current taps
- tap_row  out  clog2(IMG_HEIGHT)  row of tap_bot
- frame_done  out  1  one-cycle pulse with last pixel's taps

Behaviour:
- Reset: async, active-high; clk, single clock domain.
  - All outputs go to 0; col/row counters go to 0; delay-pipe registers go to 0.
  - Line memory contents are not reset; tap_valid gating makes them don't-care.
- Accept: each cycle with pix_valid=1 accepts pix_in at position (col,row).
  - Cycles with pix_valid=0 change nothing: counters hold, taps hold their last value, tap_valid=0, frame_done=0.
- Line buffers: two IMG_WIDTH-deep memories, lb_a (row n-1) and lb_b (row n-2).
  - Both are addressed by col with synchronous read-before-write.
  - On accept: read lb_a[col] and lb_b[col]; write lb_a[col] <= pix_in.
  - lb_b[col] is written with the lb_a read data one cycle later, at the registered col.
  - A write to lb_b never collides with a same-cycle lb_b read of a different column, so there is no hazard.
- Latency: fixed 1 cycle from accept to taps.
  - tap_bot = registered pix_in; tap_mid = lb_a read data; tap_top = lb_b read data.
  - tap_col/tap_row = registered col/row.
- tap_valid = 1 on the cycle after an accept whose row ≥2. Rows 0 and 1 are fill only and produce no valid output.
- Counters:
  - col increments per accept and wraps from IMG_WIDTH-1 to 0.
  - On wrap, row increments; row wraps from IMG_HEIGHT-1 to 0.
- frame_done asserts together with the tap_valid for (IMG_WIDTH-1, IMG_HEIGHT-1).
- sof handling:
  - sof with pix_valid=1 forces that pixel to (0,0), then counting continues from there.
  - This applies mid-frame too: the partial frame is abandoned with no frame_done, and tap_valid is suppressed until new row 2.
  - sof with pix_valid=0 is ignored.
  - sof coinciding with a natural wrap to (0,0) behaves identically to the wrap alone.
- No sof after reset: the first accepted pixel is treated as (0,0).
- Reset mid-frame: takes effect immediately; no pulse or valid is emitted afterwards until a new frame reaches row 2.

Decomposition:
- Shared package/header:
  - DATA_W default.
  - A clog2 helper function.
  - The IMG_WIDTH/IMG_HEIGHT defaults, shared with the sorter and median stages.
- One sub-module, line_buffer_ram:
  - Parameters: depth IMG_WIDTH, width DATA_W.
  - One write port and one synchronous read port, same clock.
  - Read-before-write on the same address.
  - Instantiated twice (lb_a, lb_b).
- Counters, delay registers and gating stay in line_tap_gen.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4, DATA_W=8; pixel value = row*16+col):
- Continuous frame with sof on the first pixel -> tap_valid low for the first 8 accepts.
  - First valid: (col0,row2) with top=0x00, mid=0x10, bot=0x20.
  - (col1,row2): top=0x01, mid=0x11, bot=0x21.
  - (col3,row3): top=0x13, mid=0x23, bot=0x33, with frame_done=1.
- pix_valid toggled 1/0 every cycle throughout the frame -> identical tap values and sequence to the continuous case.
  - tap_valid is low on every idle-following cycle; counters never advance on idle cycles.
- Back-to-back frames, second sof directly after 0x33 -> the second frame's first valid is (0,2) = 0x00/0x10/0x20.
  - Exactly one frame_done per frame.
- sof asserted at (col2,row2) of frame 1 -> no frame_done for frame 1.
  - tap_valid drops; the next valid taps appear at new row 2, col 0.
- rst pulsed at (col1,row3) -> all outputs are 0 within the reset cycle.
  - Resuming with sof plus a fresh frame gives the same results as the first scenario.
- pix_valid=0 with sof=1 for several cycles mid-frame -> ignored: counters and taps unchanged, and the frame completes normally with frame_done.
